// File: rtl/td4_exec_sequencer.sv
// td4_exec_sequencer: fetch/execute controller for the TD4 core.
// Fetches 4+N bit instructions from ROM over a req/ack handshake, drives the
// external adder ALU operands during EXEC and writes its result back into the
// architectural registers (A, B, OUT, PC) together with the carry flag.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   en                    run enable, sampled in FETCH
//   rom_req/addr/ack/data instruction fetch handshake (rom_addr = pc)
//   alu_a/alu_b           ALU operands (combinational, 0 outside EXEC)
//   alu_y/alu_c           ALU sum and carry out
//   in_port/out_port      external input port / registered output port
//   reg_a/reg_b/c_flag/pc architectural state
//   illegal               high during the EXEC cycle of an undefined opcode
module td4_exec_sequencer #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   output logic           rom_req,
   output logic [N-1:0]   rom_addr,
   input  logic           rom_ack,
   input  logic [N+3:0]   rom_data,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   input  logic [N-1:0]   alu_y,
   input  logic           alu_c,
   input  logic [N-1:0]   in_port,
   output logic [N-1:0]   out_port,
   output logic [N-1:0]   reg_a,
   output logic [N-1:0]   reg_b,
   output logic           c_flag,
   output logic [N-1:0]   pc,
   output logic           illegal
);

   localparam int unsigned IW = N + 4;

   typedef enum logic [0:0] {FETCH = 1'b0, EXEC = 1'b1} state_t;
   typedef enum logic [1:0] {SRC_ZERO, SRC_A, SRC_B, SRC_IN} src_t;
   typedef enum logic [2:0] {DST_NONE, DST_A, DST_B, DST_OUT, DST_JMP, DST_JNC} dst_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   ir;
   logic [3:0]      op;
   logic [N-1:0]    imm;
   logic [N-1:0]    pc_inc;
   src_t            src;
   dst_t            dst;
   logic            defined;
   logic            fetch_done;

   assign op       = ir[IW-1 -: 4];
   assign imm      = ir[N-1:0];
   assign pc_inc   = pc + N'(1);
   assign rom_addr = pc;

   // Opcode decode: operand A source and write target
   always_comb begin
      src     = SRC_ZERO;
      dst     = DST_NONE;
      defined = 1'b1;
      case (op)
         4'b0000: begin src = SRC_A;    dst = DST_A;   end
         4'b0101: begin src = SRC_B;    dst = DST_B;   end
         4'b0011: begin src = SRC_ZERO; dst = DST_A;   end
         4'b0111: begin src = SRC_ZERO; dst = DST_B;   end
         4'b0001: begin src = SRC_B;    dst = DST_A;   end
         4'b0100: begin src = SRC_A;    dst = DST_B;   end
         4'b0010: begin src = SRC_IN;   dst = DST_A;   end
         4'b0110: begin src = SRC_IN;   dst = DST_B;   end
         4'b1001: begin src = SRC_B;    dst = DST_OUT; end
         4'b1011: begin src = SRC_ZERO; dst = DST_OUT; end
         4'b1111: begin src = SRC_ZERO; dst = DST_JMP; end
         4'b1110: begin src = SRC_ZERO; dst = DST_JNC; end
         default: defined = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (fetch_done) state_nxt = EXEC;
         EXEC:    state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   // Outputs; rst_n gates rom_req so a pending request drops without a clock
   always_comb begin
      rom_req = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      illegal = 1'b0;
      case (state)
         FETCH: rom_req = en & rst_n;
         EXEC: begin
            alu_b   = imm;
            illegal = ~defined;
            case (src)
               SRC_A:   alu_a = reg_a;
               SRC_B:   alu_a = reg_b;
               SRC_IN:  alu_a = in_port;
               default: alu_a = '0;
            endcase
         end
         default: ;
      endcase
   end

   assign fetch_done = rom_req & rom_ack;

   // Instruction register and architectural state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir       <= '0;
         reg_a    <= '0;
         reg_b    <= '0;
         out_port <= '0;
         pc       <= '0;
         c_flag   <= 1'b0;
      end else if (state == FETCH) begin
         if (fetch_done) ir <= rom_data;
      end else begin
         if (defined) c_flag <= alu_c;
         // JNC tests the carry from before this instruction
         case (dst)
            DST_A:   reg_a    <= alu_y;
            DST_B:   reg_b    <= alu_y;
            DST_OUT: out_port <= alu_y;
            default: ;
         endcase
         if (dst == DST_JMP || (dst == DST_JNC && !c_flag)) pc <= alu_y;
         else                                                pc <= pc_inc;
      end
   end

endmodule

// File: doc/td4_exec_sequencer.md
Name: td4_exec_sequencer

Overview:
- Fetch/execute controller for the TD4 core. It sequences the shared N-bit adder ALU (inputs A, B; outputs Y, C).
- Fetches 8-bit instructions from program ROM over a req/ack handshake.
- Steers ALU operands, writes the ALU result into the architectural registers (A, B, OUT, PC) and latches the carry flag.
- The ALU stays a separate combinational instance; this block drives its operands and consumes its result in the same cycle.

Parameters:
- N, 4, datapath/immediate/PC width; instruction width is 4+N; opcode is the top 4 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; sampled only in FETCH
- rom_req  output  1  fetch request
- rom_addr  output  N  fetch address (= pc)
- rom_ack  input  1  ROM data valid
- rom_data  input  4+N  instruction word
- alu_a  output  N  ALU operand A (combinational)
- alu_b  output  N  ALU operand B (combinational)
- alu_y  input  N  ALU sum
- alu_c  input  1  ALU carry out
- in_port  input  N  external input port
- out_port  output  N  registered output port
- reg_a  output  N  register A
- reg_b  output  N  register B
- c_flag  output  1  carry flag register
- pc  output  N  program counter
- illegal  output  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH; reg_a, reg_b, out_port, pc, c_flag, ir, illegal, rom_req all 0. A reset during a pending fetch drops rom_req immediately and discards ir.
- FETCH state:
  - rom_req = en; rom_addr = pc.
  - While rom_req=1, rom_addr is held stable until ack.
  - On a clock edge with rom_req=1 and rom_ack=1: ir <= rom_data, go to EXEC.
  - rom_ack while rom_req=0 is ignored.
  - en=0 stalls in FETCH with no state change.
- EXEC state (exactly one cycle, then FETCH):
  - rom_req=0.
  - Im = ir[N-1:0].
  - alu_b = Im for every opcode.
  - alu_a source and write target, by opcode:
    - 0000 ADD A,Im: A+Im -> A
    - 0101 ADD B,Im: B+Im -> B
    - 0011 MOV A,Im: 0+Im -> A
    - 0111 MOV B,Im: 0+Im -> B
    - 0001 MOV A,B: B+Im -> A
    - 0100 MOV B,A: A+Im -> B
    - 0010 IN A: in_port+Im -> A
    - 0110 IN B: in_port+Im -> B
    - 1001 OUT B: B+Im -> out_port
    - 1011 OUT Im: 0+Im -> out_port
    - 1111 JMP: 0+Im -> pc
    - 1110 JNC: 0+Im -> pc only if c_flag==0 (value before this instruction); otherwise pc+1
  - Defined opcodes: c_flag <= alu_c. Sum is truncated to N bits; overflow is visible only through c_flag.
  - Non-jump defined opcodes: pc <= pc+1 (modulo 2^N; F wraps to 0). The increment uses a separate incrementer, not the ALU.
  - Undefined opcodes: no register write, c_flag held, pc <= pc+1, illegal=1 for the EXEC cycle only.
- alu_a and alu_b are don't-care but must be driven (0) outside EXEC.
- Throughput: 2 cycles per instruction when rom_ack is returned in the same cycle as rom_req; each ack-wait cycle adds 1.
- out_port changes only on OUT instructions.

Test Plan:
1. Reset
   - Stimulus: hold rst_n=0 mid-FETCH with rom_req high; then release with en=1.
   - Required: rom_req drops without a clock edge; all outputs read 0; after release, rom_req=1 and rom_addr=0 on the first cycle.
2. Arithmetic and carry (ack same cycle)
   - Stimulus: program 0x33, 0x05, 0x08, 0xE0, 0x01, 0xEA.
   - Required: A=3 then 8 (C=0), then 0 (C=1); JNC at addr 3 not taken so pc=4; A=1 (C=0); JNC taken so pc=0xA. Each instruction takes 2 cycles.
3. ROM stall
   - Stimulus: delay rom_ack by 3 cycles.
   - Required: rom_addr held and rom_req stays high for 4 cycles; no register changes until the ack edge.
   - Stimulus: en=0 in FETCH.
   - Required: rom_req=0 and the block stays idle.
4. I/O
   - Stimulus: in_port=9; program 0x22, 0x40, 0x90, 0xB7.
   - Required: A=0xB; B=0xB; out_port=0xB; then out_port=7 with C=0.
5. Illegal opcode
   - Stimulus: 0x8C with c_flag=1.
   - Required: illegal pulses for exactly 1 cycle; A, B and out_port unchanged; c_flag stays 1; pc increments.
6. PC wrap
   - Stimulus: 0xFF at addr 0 (JMP F); 0x30 at addr F.
   - Required: pc=F, then A=0 and pc wraps to 0.
